// File: rtl/alpha_blend_mixer.sv
// Alpha-blends a foreground/background RGB stream using per-column alpha read from a
// registered dual-port RAM; one pixel per clock with valid/ready backpressure.
module alpha_blend_mixer #(
  parameter int COLOR_WIDTH   = 8,
  parameter int ALPHA_WIDTH   = 8,
  parameter int ADDRESS_WIDTH = 11,
  parameter int LINE_WIDTH    = 1920
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3*COLOR_WIDTH-1:0]   in_fg,
  input  logic [3*COLOR_WIDTH-1:0]   in_bg,
  input  logic                       in_sof,
  input  logic                       in_eol,
  input  logic                       bypass,
  output logic [ADDRESS_WIDTH-1:0]   addr_b,
  input  logic [ALPHA_WIDTH-1:0]     q_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3*COLOR_WIDTH-1:0]   out_pixel,
  output logic                       out_sof,
  output logic                       out_eol
);

  localparam int PW = 3 * COLOR_WIDTH;
  localparam int MW = COLOR_WIDTH + ALPHA_WIDTH + 2;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_X = ADDRESS_WIDTH'(LINE_WIDTH - 1);
  localparam logic [MW-1:0] FULL  = MW'(1) << ALPHA_WIDTH;
  localparam logic [MW-1:0] ROUND = MW'(1) << (ALPHA_WIDTH - 1);

  logic [ADDRESS_WIDTH-1:0] xCnt_q, xCnt_d, pixAddr;
  logic                     accept, outLoad;
  logic [PW-1:0]            s1Fg_q, s1Bg_q;
  logic                     s1Sof_q, s1Eol_q, s1Valid_q, s1Valid_d, s1Fresh_q;
  logic [ALPHA_WIDTH-1:0]   alphaHold_q, alphaCur;
  logic [ALPHA_WIDTH:0]     aEff;
  logic [MW-1:0]            aExt, invExt;
  logic [PW-1:0]            blendPix, resultPix;
  logic [PW-1:0]            outPixel_q;
  logic                     outSof_q, outEol_q, outValid_q;

  assign pixAddr   = in_sof ? '0 : xCnt_q;
  assign addr_b    = pixAddr;
  assign outLoad   = s1Valid_q & (~outValid_q | out_ready);
  assign in_ready  = ~reset & (~s1Valid_q | outLoad);
  assign accept    = in_valid & in_ready;

  always_comb begin
    xCnt_d = xCnt_q;
    if (accept) begin
      xCnt_d = (in_eol || pixAddr == LAST_X) ? '0 : pixAddr + ADDRESS_WIDTH'(1);
    end
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    if (accept) begin
      s1Valid_d = 1'b1;
    end else if (outLoad) begin
      s1Valid_d = 1'b0;
    end
  end

  // RAM data is only valid the cycle after acceptance; a stalled S1 must use the held copy.
  assign alphaCur = s1Fresh_q ? q_b : alphaHold_q;
  assign aEff     = {1'b0, alphaCur} + (ALPHA_WIDTH + 1)'(alphaCur[ALPHA_WIDTH-1]);
  assign aExt     = MW'(aEff);
  assign invExt   = FULL - aExt;

  for (genvar c = 0; c < 3; c++) begin : gChan
    logic [MW-1:0] fgExt, bgExt;
    assign fgExt = MW'(s1Fg_q[c*COLOR_WIDTH +: COLOR_WIDTH]);
    assign bgExt = MW'(s1Bg_q[c*COLOR_WIDTH +: COLOR_WIDTH]);
    assign blendPix[c*COLOR_WIDTH +: COLOR_WIDTH] =
      COLOR_WIDTH'((aExt * fgExt + invExt * bgExt + ROUND) >> ALPHA_WIDTH);
  end

  assign resultPix = bypass ? s1Fg_q : blendPix;

  always_ff @(posedge clk) begin
    if (accept) begin
      s1Fg_q  <= in_fg;
      s1Bg_q  <= in_bg;
      s1Sof_q <= in_sof;
      s1Eol_q <= in_eol;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xCnt_q      <= '0;
      s1Valid_q   <= 1'b0;
      s1Fresh_q   <= 1'b0;
      alphaHold_q <= '0;
      outValid_q  <= 1'b0;
      outPixel_q  <= '0;
      outSof_q    <= 1'b0;
      outEol_q    <= 1'b0;
    end else begin
      xCnt_q    <= xCnt_d;
      s1Valid_q <= s1Valid_d;
      s1Fresh_q <= accept;
      if (s1Fresh_q) begin
        alphaHold_q <= q_b;
      end
      if (outLoad) begin
        outPixel_q <= resultPix;
        outSof_q   <= s1Sof_q;
        outEol_q   <= s1Eol_q;
        outValid_q <= 1'b1;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_pixel = outPixel_q;
  assign out_sof   = outSof_q;
  assign out_eol   = outEol_q;

endmodule

// File: tb/tb_alpha_blend_mixer.sv
// Scoreboard bench for alpha_blend_mixer: directed pixels push expected results,
// an output monitor pops and compares them; includes a registered alpha RAM model.
module tb_alpha_blend_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [23:0] in_fg, in_bg;
  logic        in_sof, in_eol, bypass;
  logic [10:0] addr_b;
  logic [7:0]  q_b;
  logic        out_valid, out_ready;
  logic [23:0] out_pixel;
  logic        out_sof, out_eol;

  typedef struct {
    logic [23:0] pix;
    logic        sof;
    logic        eol;
    int          acc;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  ramMem [0:3];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  logic        checkLatency = 1'b0;

  alpha_blend_mixer #(
    .COLOR_WIDTH(8), .ALPHA_WIDTH(8), .ADDRESS_WIDTH(11), .LINE_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fg(in_fg), .in_bg(in_bg), .in_sof(in_sof), .in_eol(in_eol),
    .bypass(bypass), .addr_b(addr_b), .q_b(q_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Registered-read RAM: data for addr_b appears after the next rising edge.
  always @(posedge clk) q_b <= (addr_b < 11'd4) ? ramMem[addr_b[1:0]] : 8'hEE;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] blendRef(input logic [23:0] fg, input logic [23:0] bg,
                                           input logic [7:0] a, input logic byp);
    logic [23:0] r;
    int ae, f, b;
    if (byp) return fg;
    ae = int'(a) + int'(a[7]);
    for (int c = 0; c < 3; c++) begin
      f = int'(fg[c*8 +: 8]);
      b = int'(bg[c*8 +: 8]);
      r[c*8 +: 8] = 8'((ae * f + (256 - ae) * b + 128) >> 8);
    end
    return r;
  endfunction

  // Holds the pixel until accepted, checks the RAM address, and records the expectation.
  task automatic applyStimulus(input logic [23:0] fg, input logic [23:0] bg,
                               input logic sof, input logic eol,
                               input logic [10:0] expAddr, input logic [23:0] expPix,
                               output int waits);
    exp_t e;
    in_fg = fg; in_bg = bg; in_sof = sof; in_eol = eol; in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready) begin
      checkOutput("addr_b", 32'(addr_b), 32'(expAddr));
      e.pix = expPix; e.sof = sof; e.eol = eol; e.acc = cycle;
      expQ.push_back(e);
    end else begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idleInput();
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic setRam(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3);
    ramMem[0] = a0; ramMem[1] = a1; ramMem[2] = a2; ramMem[3] = a3;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("extra_output", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_pixel", 32'(out_pixel), 32'(e.pix));
        checkOutput("out_sof", 32'(out_sof), 32'(e.sof));
        checkOutput("out_eol", 32'(out_eol), 32'(e.eol));
        if (checkLatency) checkOutput("latency", 32'(cycle - e.acc), 32'd2);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    int bpWaits[4];
    logic [23:0] fgv, bgv, held;
    logic heldSet;
    logic [10:0] addrSeq[6];

    reset = 1'b1; bypass = 1'b0; out_ready = 1'b1;
    in_fg = '0; in_bg = '0; idleInput();
    for (int i = 0; i < 4; i++) ramMem[i] = 8'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_pixel", 32'(out_pixel), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_reset_addr", 32'(addr_b), 32'd0);
    @(posedge clk); #1;

    $display("[TB] blend arithmetic");
    setRam(8'd0, 8'd0, 8'd0, 8'd0);
    applyStimulus({3{8'd200}}, {3{8'd100}}, 1'b1, 1'b0, 11'd0, {3{8'd100}}, w);
    idleInput(); waitDrain();
    setRam(8'd128, 8'd128, 8'd128, 8'd128);
    applyStimulus({3{8'd200}}, {3{8'd100}}, 1'b1, 1'b0, 11'd0, {3{8'd150}}, w);
    idleInput(); waitDrain();
    setRam(8'd255, 8'd255, 8'd255, 8'd255);
    applyStimulus({3{8'd200}}, {3{8'd100}}, 1'b1, 1'b0, 11'd0, {3{8'd200}}, w);
    idleInput(); waitDrain();
    setRam(8'd0, 8'd0, 8'd0, 8'd0);
    bypass = 1'b1;
    applyStimulus({3{8'd200}}, {3{8'd100}}, 1'b1, 1'b0, 11'd0, {3{8'd200}}, w);
    idleInput(); waitDrain();
    bypass = 1'b0;

    $display("[TB] addressing and throughput");
    setRam(8'd10, 8'd70, 8'd130, 8'd250);
    addrSeq = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd0, 11'd1};
    checkLatency = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fgv = {8'(i * 30), 8'(255 - i * 20), 8'(i * 7)};
      bgv = {8'(250 - i * 11), 8'(i * 40), 8'd128};
      applyStimulus(fgv, bgv, i == 0, i == 5, addrSeq[i],
                    blendRef(fgv, bgv, ramMem[addrSeq[i][1:0]], 1'b0), w);
      checkOutput("stream_stall", 32'(w), 32'd0);
    end
    idleInput(); waitDrain();

    $display("[TB] early eol and sof+eol");
    addrSeq = '{11'd0, 11'd1, 11'd2, 11'd0, 11'd1, 11'd0};
    for (int i = 0; i < 6; i++) begin
      fgv = {8'(i * 41), 8'd60, 8'(200 - i * 9)};
      bgv = {8'd5, 8'(i * 33), 8'd240};
      applyStimulus(fgv, bgv, (i == 0) || (i == 5), (i == 2) || (i == 5), addrSeq[i],
                    blendRef(fgv, bgv, ramMem[addrSeq[i][1:0]], 1'b0), w);
    end
    applyStimulus(24'h123456, 24'hABCDEF, 1'b0, 1'b0, 11'd0,
                  blendRef(24'h123456, 24'hABCDEF, ramMem[0], 1'b0), w);
    idleInput(); waitDrain();
    checkLatency = 1'b0;

    $display("[TB] backpressure");
    setRam(8'd0, 8'd50, 8'd100, 8'd150);
    out_ready = 1'b0;
    heldSet = 1'b0;
    held = '0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          fgv = {8'd200, 8'd10, 8'd255};
          bgv = {8'd100, 8'd90, 8'd0};
          applyStimulus(fgv, bgv, i == 0, 1'b0, 11'(i),
                        blendRef(fgv, bgv, 8'(i * 50), 1'b0), bpWaits[i]);
        end
        idleInput();
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (out_valid) begin
            if (heldSet) checkOutput("stall_stable", 32'(out_pixel), 32'(held));
            else begin
              held = out_pixel;
              heldSet = 1'b1;
            end
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_wait0", 32'(bpWaits[0]), 32'd0);
    checkOutput("bp_wait1", 32'(bpWaits[1]), 32'd0);
    checkOutput("bp_wait2_stalled", 32'(bpWaits[2] > 0), 32'd1);
    checkOutput("bp_held_seen", 32'(heldSet), 32'd1);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(24'h808080, 24'h101010, 1'b1, 1'b0, 11'd0, 24'h0, w);
    applyStimulus(24'h909090, 24'h202020, 1'b0, 1'b0, 11'd1, 24'h0, w);
    idleInput();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(24'h40C020, 24'hC04080, 1'b0, 1'b1, 11'd0,
                  blendRef(24'h40C020, 24'hC04080, ramMem[0], 1'b0), w);
    idleInput(); waitDrain();

    checkOutput("leftover", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
